// File: rtl/led_pkg.sv
// Shared mode constants and debounce state encoding for the LED mode controller.
package led_pkg;

   localparam logic [1:0] MODE_RUN_DN = 2'd0;
   localparam logic [1:0] MODE_RUN_UP = 2'd1;
   localparam logic [1:0] MODE_FILL   = 2'd2;
   localparam logic [1:0] MODE_DRAIN  = 2'd3;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } deb_state_t;

   // Next mode in the button/auto stepping order; 3 wraps to 0.
   function automatic logic [1:0] mode_step(input logic [1:0] mode);
      return mode + 2'd1;
   endfunction

endpackage

// File: rtl/led_mode_ctrl_if.sv
// Host mode-set command port: valid/ready handshake carrying the requested mode.
interface led_mode_ctrl_if;

   logic       cmd_valid;
   logic [1:0] cmd_mode;
   logic       cmd_ready;

   modport master (
      output cmd_valid,
      output cmd_mode,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_mode,
      output cmd_ready
   );

endinterface

// File: rtl/led_mode_ctrl_key_debounce.sv
// Push-button synchronizer and debounce FSM; emits one key_evt pulse per accepted press.
module key_debounce
   import led_pkg::*;
#(
   parameter int DEB_CYCLES = 800_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic key_evt
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

   logic          sync1_reg;
   logic          sync2_reg;
   deb_state_t    state_reg;
   deb_state_t    state_next;
   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;
   logic          key_evt_reg;
   logic          key_evt_next;
   logic          key_low;

   assign key_low = ~sync2_reg;
   assign key_evt = key_evt_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_reg   <= 1'b1;
         sync2_reg   <= 1'b1;
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         key_evt_reg <= 1'b0;
      end else begin
         sync1_reg   <= key_n;
         sync2_reg   <= sync1_reg;
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         key_evt_reg <= key_evt_next;
      end
   end

   // The counter only advances below CNT_MAX, so it can never wrap.
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      key_evt_next = 1'b0;
      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            if (key_low) state_next = PRESS_WAIT;
         end
         PRESS_WAIT: begin
            if (!key_low) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_MAX) begin
               state_next   = HELD;
               cnt_next     = '0;
               key_evt_next = 1'b1;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         HELD: begin
            cnt_next = '0;
            if (!key_low) state_next = RELEASE_WAIT;
         end
         RELEASE_WAIT: begin
            if (key_low) begin
               state_next = HELD;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_MAX) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

endmodule

// File: rtl/led_mode_ctrl.sv
// Owner of the pattern engine's ctrl mode: arbitrates key, host and auto-cycle changes.
// Auto-cycle dwell timer is built only when LED_AUTO_CYCLE_EN is defined.
module led_mode_ctrl
   import led_pkg::*;
#(
   parameter int DEB_CYCLES  = 800_000,
   parameter int AUTO_CYCLES = 200_000_000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  key_n,
   led_mode_ctrl_if.slave        cmd,
   input  logic                  auto_en,
   output logic [1:0]            ctrl,
   output logic                  ctrl_chg
);

   logic       key_evt;
   logic       ready_en_reg;
   logic       accept;
   logic       auto_tick;
   logic [1:0] ctrl_reg;
   logic [1:0] ctrl_next;
   logic       ctrl_chg_reg;
   logic       ctrl_chg_next;

   key_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_key_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_n   (key_n),
      .key_evt (key_evt)
   );

   // A key event owns its cycle; the host simply retries on the next one.
   assign cmd.cmd_ready = ready_en_reg & ~key_evt;
   assign accept        = cmd.cmd_valid & cmd.cmd_ready;
   assign ctrl          = ctrl_reg;
   assign ctrl_chg      = ctrl_chg_reg;

`ifdef LED_AUTO_CYCLE_EN
   localparam int AW = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
   localparam logic [AW-1:0] DWELL_MAX = AW'(AUTO_CYCLES - 1);

   logic [AW-1:0] dwell_reg;

   assign auto_tick = auto_en & (dwell_reg == DWELL_MAX);

   // Any applied change restarts the dwell, so a dropped tick also restarts it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dwell_reg <= '0;
      end else if (ctrl_chg_next || !auto_en) begin
         dwell_reg <= '0;
      end else begin
         dwell_reg <= dwell_reg + AW'(1);
      end
   end
`else
   logic unused_auto_en;

   assign unused_auto_en = auto_en;
   assign auto_tick      = 1'b0;
`endif

   always_comb begin
      ctrl_next     = ctrl_reg;
      ctrl_chg_next = 1'b0;
      if (key_evt) begin
         ctrl_next     = mode_step(ctrl_reg);
         ctrl_chg_next = 1'b1;
      end else if (accept) begin
         ctrl_next     = cmd.cmd_mode;
         ctrl_chg_next = 1'b1;
      end else if (auto_tick) begin
         ctrl_next     = mode_step(ctrl_reg);
         ctrl_chg_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ready_en_reg <= 1'b0;
         ctrl_reg     <= MODE_RUN_DN;
         ctrl_chg_reg <= 1'b0;
      end else begin
         ready_en_reg <= 1'b1;
         ctrl_reg     <= ctrl_next;
         ctrl_chg_reg <= ctrl_chg_next;
      end
   end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl with a run-length behavioural model checked every cycle.
module tb_led_mode_ctrl;
   import led_pkg::*;

   localparam int DEB  = 8;
   localparam int AUTO = 32;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_n = 1'b1;
   logic       auto_en = 1'b0;
   logic [1:0] ctrl;
   logic       ctrl_chg;

   led_mode_ctrl_if cmd_bus ();

   always #5 clk = ~clk;

   led_mode_ctrl #(
      .DEB_CYCLES  (DEB),
      .AUTO_CYCLES (AUTO)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_n    (key_n),
      .cmd      (cmd_bus),
      .auto_en  (auto_en),
      .ctrl     (ctrl),
      .ctrl_chg (ctrl_chg)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int chg_cnt = 0;
   int last_chg = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: a press is a run of DEB+1 synced-low samples while armed; re-arm after DEB+1 highs.
   logic [1:0] m_ctrl;
   bit m_chg, m_ready_en, m_evt, m_armed, kd1, kd2, m_rdy, m_tick, m_s;
   int low_run, high_run, m_dwell;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst_n) begin
         m_ctrl = 2'd0; m_chg = 0; m_ready_en = 0; m_evt = 0; m_armed = 1;
         kd1 = 1; kd2 = 1; low_run = 0; high_run = 0; m_dwell = 0;
      end else begin
         m_rdy  = m_ready_en && !m_evt;
         m_tick = 0;
`ifdef LED_AUTO_CYCLE_EN
         m_tick = auto_en && (m_dwell == AUTO - 1);
`endif
         m_chg = 1;
         if (m_evt) m_ctrl = m_ctrl + 2'd1;
         else if (cmd_bus.cmd_valid && m_rdy) m_ctrl = cmd_bus.cmd_mode;
         else if (m_tick) m_ctrl = m_ctrl + 2'd1;
         else m_chg = 0;
         m_dwell = (m_chg || !auto_en) ? 0 : m_dwell + 1;
         m_ready_en = 1;
         m_s = kd2; kd2 = kd1; kd1 = key_n;
         m_evt = 0;
         if (!m_s) begin
            low_run++; high_run = 0;
            if (m_armed && low_run == DEB + 1) begin m_evt = 1; m_armed = 0; end
         end else begin
            high_run++; low_run = 0;
            if (!m_armed && high_run == DEB + 1) m_armed = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("ctrl", 32'(ctrl), 32'(m_ctrl));
         check("ctrl_chg", 32'(ctrl_chg), 32'(m_chg));
         check("cmd_ready", 32'(cmd_bus.cmd_ready), 32'(m_ready_en && !m_evt));
      end
      if (ctrl_chg === 1'b1) begin
         chg_cnt++;
         last_chg = cyc;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic press(input int low_len, output int k);
      k = cyc;
      key_n = 1'b0;
      tick(low_len);
      key_n = 1'b1;
      tick(20);
   endtask

   task automatic host_cmd(input logic [1:0] mode, output int waits);
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_mode  = mode;
      waits = 0;
      while (cmd_bus.cmd_ready !== 1'b1 && waits < 20) begin
         tick(1);
         waits++;
      end
      if (waits == 20) check("host_timeout", 32'(waits), 32'd0);
      tick(1);
      cmd_bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_chg(input int bound, output int t);
      int c0, n;
      c0 = chg_cnt;
      n  = 0;
      while (chg_cnt == c0 && n < bound) begin
         tick(1);
         n++;
      end
      if (n == bound) check("chg_timeout", 32'(n), 32'd0);
      t = last_chg;
   endtask

   initial begin
      int k, c0, w, t1, t2, t3;
      int exp_seq[4];
      exp_seq = '{1, 2, 3, 0};
      cmd_bus.cmd_valid = 1'b0;
      cmd_bus.cmd_mode  = 2'd0;
      tick(1);
      cmp_en = 1'b1;
      check("rst_ctrl", 32'(ctrl), 32'd0);
      check("rst_chg", 32'(ctrl_chg), 32'd0);
      check("rst_ready", 32'(cmd_bus.cmd_ready), 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      check("ready_after_rst", 32'(cmd_bus.cmd_ready), 32'd1);

      c0 = chg_cnt;
      tick(100);
      check("idle_chg", 32'(chg_cnt - c0), 32'd0);
      check("idle_ctrl", 32'(ctrl), 32'd0);

      for (int i = 0; i < 4; i++) begin
         c0 = chg_cnt;
         press(20, k);
         check("press_chg", 32'(chg_cnt - c0), 32'd1);
         check("press_latency", 32'(last_chg - (k + 1)), 32'd11);
         check("press_ctrl", 32'(ctrl), 32'(exp_seq[i]));
      end

      c0 = chg_cnt;
      repeat (4) begin
         key_n = 1'b0; tick(5);
         key_n = 1'b1; tick(2);
      end
      tick(20);
      check("bounce_chg", 32'(chg_cnt - c0), 32'd0);
      check("bounce_ctrl", 32'(ctrl), 32'd0);

      c0 = chg_cnt;
      press(500, k);
      check("hold_chg", 32'(chg_cnt - c0), 32'd1);
      check("hold_ctrl", 32'(ctrl), 32'd1);

      for (int i = 0; i < 2; i++) begin
         c0 = chg_cnt;
         host_cmd(2'd3, w);
         check("host_waits", 32'(w), 32'd0);
         check("host_ctrl", 32'(ctrl), 32'd3);
         check("host_chg", 32'(chg_cnt - c0), 32'd1);
      end
      host_cmd(2'd0, w);
      check("host_zero", 32'(ctrl), 32'd0);

      k = cyc;
      key_n = 1'b0;
      tick(11);
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_mode  = 2'd2;
      check("conflict_ready", 32'(cmd_bus.cmd_ready), 32'd0);
      tick(1);
      check("conflict_key_ctrl", 32'(ctrl), 32'd1);
      check("conflict_key_chg", 32'(ctrl_chg), 32'd1);
      tick(1);
      check("conflict_host_ctrl", 32'(ctrl), 32'd2);
      check("conflict_host_chg", 32'(ctrl_chg), 32'd1);
      check("conflict_cycle", 32'(cyc - k), 32'd13);
      cmd_bus.cmd_valid = 1'b0;
      tick(10);
      key_n = 1'b1;
      tick(20);

      c0 = chg_cnt;
      key_n = 1'b0;
      tick(5);
      rst_n = 1'b0;
      tick(2);
      key_n = 1'b1;
      rst_n = 1'b1;
      tick(20);
      check("midrst_chg", 32'(chg_cnt - c0), 32'd0);
      check("midrst_ctrl", 32'(ctrl), 32'd0);

`ifdef LED_AUTO_CYCLE_EN
      auto_en = 1'b1;
      wait_chg(40, t1);
      wait_chg(40, t2);
      check("auto_period", 32'(t2 - t1), 32'd32);
      check("auto_ctrl", 32'(ctrl), 32'd2);
      tick(10);
      host_cmd(2'd1, w);
      t1 = last_chg;
      wait_chg(40, t3);
      check("auto_restart", 32'(t3 - t1), 32'd32);
      check("auto_after_host", 32'(ctrl), 32'd2);
      auto_en = 1'b0;
      tick(5);
`else
      auto_en = 1'b1;
      c0 = chg_cnt;
      tick(200);
      check("noauto_chg", 32'(chg_cnt - c0), 32'd0);
      check("noauto_ctrl", 32'(ctrl), 32'd0);
      auto_en = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/led_mode_ctrl.md
# led_mode_ctrl

Mode controller for the 4-LED pattern engine: it sequences and owns the engine's 2-bit `ctrl` input. Two requesters can change the mode: a local push-button, which is debounced and steps the mode, and a host command port, which sets the mode directly. An optional auto-cycle timer also steps the mode. The block sits between board I/O / host logic and the pattern engine, and it is the only driver of `ctrl`.

## Interface
Parameters:
- DEB_CYCLES, 800_000 — cycles the key must be stable before an edge is accepted (20 ms at 40 MHz); minimum 2
- AUTO_CYCLES, 200_000_000 — dwell cycles per mode in auto-cycle (5 s at 40 MHz); minimum 2

Ports:
- clk  in  1  system clock; the block has one clock
- rst_n  in  1  synchronous reset, active-low
- key_n  in  1  raw push-button, active-low, asynchronous to clk
- cmd_valid  in  1  host mode-set request
- cmd_mode  in  2  requested mode; qualified by cmd_valid
- cmd_ready  out  1  host request accepted in any cycle where cmd_valid & cmd_ready
- auto_en  in  1  enable auto-cycle (only used with LED_AUTO_CYCLE_EN)
- ctrl  out  2  mode to the pattern engine: 0 run high→low, 1 run low→high, 2 fill up, 3 drain down
- ctrl_chg  out  1  one-cycle pulse in the first cycle that ctrl holds a new value

## Operation
- key_n passes through a 2-flop synchronizer into the debounce FSM.
- Debounce FSM states and transitions:
  - IDLE → PRESS_WAIT when the synced key is low.
  - PRESS_WAIT → HELD after DEB_CYCLES consecutive low samples; this transition emits key_evt.
  - PRESS_WAIT → IDLE on any high sample; the counter clears.
  - HELD → RELEASE_WAIT when the key goes high.
  - RELEASE_WAIT → IDLE after DEB_CYCLES consecutive high samples.
  - RELEASE_WAIT → HELD on any low sample.
- One key_evt is produced per press. Holding the key never repeats the event.
- key_evt: ctrl ← ctrl + 1, modulo 4 (3 wraps to 0).
- Host handshake:
  - cmd_ready = 1 except in reset and in a cycle where key_evt fires.
  - On accept, ctrl ← cmd_mode.
  - The host must hold cmd_valid and cmd_mode stable until accepted.
- Arbitration priority, fixed: key_evt > host command > auto tick. Only one change is applied per cycle.
- A deferred host command is accepted in the next cycle. The auto tick in a conflicting cycle is dropped, and the auto timer restarts.
- ctrl_chg pulses for every applied change, including a host command whose value equals the current ctrl.
- The auto timer clears on any applied change, whatever its source.

## Timing
- Reset (rst_n low at a clk edge):
  - ctrl = 0, ctrl_chg = 0, cmd_ready = 0.
  - Debounce FSM → IDLE; all counters cleared; synchronizer flops set to 1.
- Reset asserted mid-debounce or mid-dwell abandons the operation. No event is produced.
- Key latency: the key goes low at edge N. The synced value is seen at N+2, key_evt is registered at N+2+DEB_CYCLES, and ctrl/ctrl_chg update one cycle later.
- Host latency: accepted at edge N; ctrl and ctrl_chg are valid after edge N (registered, 1 cycle).
- Auto tick fires when the dwell counter reaches AUTO_CYCLES−1. The counter then wraps to 0 and ctrl steps.
- Counter widths are $clog2 of the parameter. Counters saturate and never wrap inside the debounce FSM.
- The pattern engine samples ctrl only on its 0.5 s tick. Sub-tick ctrl glitches are therefore tolerated, but ctrl is glitch-free because it is registered.

## Configuration
- LED_AUTO_CYCLE_EN defined:
  - The dwell counter and auto tick are built.
  - With auto_en = 1, the mode steps every AUTO_CYCLES cycles.
  - With auto_en = 0, the counter is held at 0.
- LED_AUTO_CYCLE_EN undefined:
  - No dwell counter exists; auto_en is unused and ignored.
  - ctrl changes only on key or host events.

## Structure
- Package led_pkg:
  - mode constants MODE_RUN_DN = 2'd0, MODE_RUN_UP = 2'd1, MODE_FILL = 2'd2, MODE_DRAIN = 2'd3
  - debounce state encoding (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT)
- Sub-module key_debounce holds the synchronizer, debounce FSM and counter. It outputs the key_evt pulse.
- led_mode_ctrl holds the arbitration, the ctrl register, the handshake and the auto timer.

## Test plan
Bench uses DEB_CYCLES = 8 and AUTO_CYCLES = 32.
- Reset, then idle 100 cycles → ctrl = 0, ctrl_chg never asserted, cmd_ready = 1 from the first cycle after reset release.
- Key low for 20 cycles, then high → exactly one ctrl_chg, ctrl = 1, with the change 11 cycles after the falling edge. Four such presses give ctrl 1, 2, 3, 0 (wrap).
- Key bounce (low 5 cycles, high 2, repeated 4×) → no ctrl change. Key held low for 500 cycles → a single step only.
- Host cmd_mode = 3 with cmd_valid high → accepted in 1 cycle, ctrl = 3, one ctrl_chg. Repeating cmd_mode = 3 → ctrl_chg pulses again.
- key_evt and cmd_valid (cmd_mode = 2) in the same cycle, with ctrl = 0 → ctrl = 1 first, cmd_ready low that cycle, ctrl = 2 next cycle, two ctrl_chg pulses.
- With LED_AUTO_CYCLE_EN and auto_en = 1 → ctrl steps every 32 cycles. A host command mid-dwell restarts the count. Without the macro, auto_en = 1 causes no change over 200 cycles.
